decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of token, vocab and output memories.
REQ-002 Parameter DATA_WIDTH, default 8, byte width of all memory data.
REQ-003 Parameter SEP, default 8'h20, separator byte written between decoded words.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cs  input  1  start request, sampled in IDLE only.
REQ-007 tok_addr  output  ADDR_WIDTH  token memory read address.
REQ-008 tok_rdata  input  DATA_WIDTH  token memory read data, valid one cycle after tok_addr.
REQ-009 voc_addr  output  ADDR_WIDTH  vocab memory read address.
REQ-010 voc_rdata  input  DATA_WIDTH  vocab memory read data, valid one cycle after voc_addr.
REQ-011 out_addr  output  ADDR_WIDTH  output memory write address.
REQ-012 out_wdata  output  DATA_WIDTH  output memory write data.
REQ-013 out_we  output  1  output memory write strobe, one byte per cycle when high.
REQ-014 done  output  1  decode complete, sticky until next accepted cs.
REQ-015 err  output  1  invalid token or output truncation occurred, sticky until next accepted cs.

Function
REQ-016 Vocab holds null-terminated words packed from address 0; token value k>=1 selects the k-th word (1-based); token 0 ends the stream.
REQ-017 Output is the selected words in token order, SEP between consecutive words, single 0 terminator after the last byte.
REQ-018 States: IDLE, TOK_RD, TOK_CHK, SEP_WR, SEEK_RD, SEEK_CHK, COPY_RD, COPY_CHK, TERM, DONE.
REQ-019 IDLE: on cs=1 clear tp, op, va, first-word flag, done, err; next TOK_RD; cs=0 holds IDLE.
REQ-020 TOK_RD drives tok_addr=tp; next TOK_CHK.
REQ-021 TOK_CHK: tok_rdata=0 -> TERM; else latch cnt=tok_rdata-1, va=0; next SEP_WR if a word was already emitted, else SEEK_RD.
REQ-022 SEP_WR writes SEP at op, op+1; next SEEK_RD.
REQ-023 SEEK_RD drives voc_addr=va; SEEK_CHK: if cnt=0 go COPY_RD (va unchanged); else va+1, cnt-1 when voc_rdata=0, back to SEEK_RD.
REQ-024 SEEK increment wrapping va from all-ones to 0 sets err, skips token (tp+1), next TOK_RD; no bytes of that token written beyond an already-written SEP.
REQ-025 COPY_RD drives voc_addr=va; COPY_CHK: voc_rdata!=0 -> write byte at op, op+1, va+1, back to COPY_RD; voc_rdata=0 -> set first-word flag, tp+1, next TOK_RD.
REQ-026 Last output address (all-ones) reserved for terminator: any SEP or data write targeting it is suppressed, err set, next TERM.
REQ-027 tp increment wrapping from all-ones to 0 goes to TERM without error.
REQ-028 TERM writes 0 at op; next DONE; DONE sets done=1, next IDLE.
REQ-029 out_we high only in SEP_WR, COPY_CHK (non-zero byte) and TERM; exactly one cycle per byte.
REQ-030 Latency per copied byte 2 cycles, per skipped vocab byte 2 cycles, per token fetch 2 cycles.

Reset
REQ-031 rst=1 asynchronously forces IDLE, tp=op=va=cnt=0, done=0, err=0, out_we=0, all addresses 0, out_wdata=0.
REQ-032 rst asserted mid-decode abandons the operation; no further writes; restart needs a new cs.

Structure
REQ-033 Package decoder_pkg holds the state enum and the default SEP constant.
REQ-034 No sub-modules; memories are instantiated by the parent with the shared sram block.

Verification (vocab 0..8 = 68 69 00 79 6F 00 6F 6B 00)
REQ-035 tokens 02 01 00, pulse cs -> out 79 6F 20 68 69 00 at 0..5, done=1, err=0.
REQ-036 tokens 00 -> single write 00 at addr 0, done=1, err=0.
REQ-037 tokens 05 00 -> vocab scan wraps, err=1, out[0]=00, done=1.
REQ-038 tokens 01 x8 00 -> out 68 69 (20 68 69)x4 20 at 0..14, 00 at 15, err=1, done=1.
REQ-039 rst pulsed during COPY of tokens 03 00 -> out_we low same cycle, done=0; new cs -> out 6F 6B 00, done=1.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the token decoder.
//   state_t     - FSM state encoding
//   SEP_DEFAULT - default separator byte placed between decoded words
package decoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TOK_RD   = 4'd1,
    S_TOK_CHK  = 4'd2,
    S_SEP_WR   = 4'd3,
    S_SEEK_RD  = 4'd4,
    S_SEEK_CHK = 4'd5,
    S_COPY_RD  = 4'd6,
    S_COPY_CHK = 4'd7,
    S_TERM     = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [7:0] SEP_DEFAULT = 8'h20;

endpackage

// File: rtl/decoder.sv
// decoder: turns a zero-terminated token stream into text by looking up each
// token in a vocabulary of null-terminated words and writing the words, joined
// by SEP and ended by a single 0 byte, into an output memory.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cs                  - start request (taken only while idle)
//   tok_addr/tok_rdata  - token memory read port (1-cycle read latency)
//   voc_addr/voc_rdata  - vocab memory read port (1-cycle read latency)
//   out_addr/out_wdata/out_we - output memory write port
//   done, err           - sticky status, cleared by the next accepted cs
module decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP = DATA_WIDTH'(SEP_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_rdata,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_rdata,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic                  out_we,
  output logic                  done,
  output logic                  err
);

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] tp_r, tp_s;
  logic [ADDR_WIDTH-1:0] op_r, op_s;
  logic [ADDR_WIDTH-1:0] va_r, va_s;
  logic [DATA_WIDTH-1:0] cnt_r, cnt_s;
  logic                  first_r, first_s;  // a word has already been emitted
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic                  we_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      tp_r    <= '0;
      op_r    <= '0;
      va_r    <= '0;
      cnt_r   <= '0;
      first_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      tp_r    <= tp_s;
      op_r    <= op_s;
      va_r    <= va_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Next-state, datapath update and write-port decode.
  always_comb begin
    state_s = state_r;
    tp_s    = tp_r;
    op_s    = op_r;
    va_s    = va_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    done_s  = done_r;
    err_s   = err_r;
    we_s    = 1'b0;
    wdata_s = '0;
    case (state_r)
      S_IDLE: begin
        if (cs) begin
          tp_s    = '0;
          op_s    = '0;
          va_s    = '0;
          first_s = 1'b0;
          done_s  = 1'b0;
          err_s   = 1'b0;
          state_s = S_TOK_RD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_TOK_RD: state_s = S_TOK_CHK;
      S_TOK_CHK: begin
        if (tok_rdata == '0) begin
          state_s = S_TERM;
        end else begin
          cnt_s = tok_rdata - DATA_WIDTH'(1);
          va_s  = '0;
          if (first_r) state_s = S_SEP_WR;
          else         state_s = S_SEEK_RD;
        end
      end
      S_SEP_WR: begin
        // The last output slot is kept for the terminator.
        if (op_r == '1) begin
          err_s   = 1'b1;
          state_s = S_TERM;
        end else begin
          we_s    = 1'b1;
          wdata_s = SEP;
          op_s    = op_r + ADDR_WIDTH'(1);
          state_s = S_SEEK_RD;
        end
      end
      S_SEEK_RD: state_s = S_SEEK_CHK;
      S_SEEK_CHK: begin
        if (cnt_r == '0) begin
          state_s = S_COPY_RD;
        end else if (va_r == '1) begin
          // Ran off the end of the vocab: drop this token.
          err_s = 1'b1;
          tp_s  = tp_r + ADDR_WIDTH'(1);
          if (tp_r == '1) state_s = S_TERM;
          else            state_s = S_TOK_RD;
        end else begin
          va_s = va_r + ADDR_WIDTH'(1);
          if (voc_rdata == '0) cnt_s = cnt_r - DATA_WIDTH'(1);
          else                 cnt_s = cnt_r;
          state_s = S_SEEK_RD;
        end
      end
      S_COPY_RD: state_s = S_COPY_CHK;
      S_COPY_CHK: begin
        if (voc_rdata != '0) begin
          if (op_r == '1) begin
            err_s   = 1'b1;
            state_s = S_TERM;
          end else begin
            we_s    = 1'b1;
            wdata_s = voc_rdata;
            op_s    = op_r + ADDR_WIDTH'(1);
            va_s    = va_r + ADDR_WIDTH'(1);
            state_s = S_COPY_RD;
          end
        end else begin
          first_s = 1'b1;
          tp_s    = tp_r + ADDR_WIDTH'(1);
          // Token pointer wrap ends the stream cleanly.
          if (tp_r == '1) state_s = S_TERM;
          else            state_s = S_TOK_RD;
        end
      end
      S_TERM: begin
        we_s    = 1'b1;
        wdata_s = '0;
        state_s = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Addresses come straight from the pointer registers; the write strobe and
  // data are decoded from state so a byte lands in the cycle it is checked.
  assign tok_addr  = tp_r;
  assign voc_addr  = va_r;
  assign out_addr  = op_r;
  assign out_we    = we_s;
  assign out_wdata = wdata_s;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic [3:0] tok_addr, voc_addr, out_addr;
  logic [7:0] tok_rdata, voc_rdata, out_wdata;
  logic       out_we, done, err;

  logic [7:0] tok_mem [16];
  logic [7:0] voc_mem [16];
  logic [7:0] out_mem [16];
  int         wr_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SEP(8'h20)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .tok_addr(tok_addr), .tok_rdata(tok_rdata),
    .voc_addr(voc_addr), .voc_rdata(voc_rdata),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_we(out_we),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories and output write port.
  always @(posedge clk) begin
    tok_rdata <= tok_mem[tok_addr];
    voc_rdata <= voc_mem[voc_addr];
    if (out_we) begin
      out_mem[out_addr] <= out_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic prep(input logic [7:0] t0, input logic [7:0] t1);
    for (int i = 0; i < 16; i++) begin
      tok_mem[i] = 8'h00;
      out_mem[i] = 8'hEE;
    end
    tok_mem[0] = t0;
    tok_mem[1] = t1;
  endtask

  // Pulse cs and wait for done; cyc counts edges after cs is accepted.
  task automatic run_decode(output int cyc, output bit timed_out);
    @(negedge clk) cs = 1'b1;
    @(negedge clk) cs = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = !done;
    n_cmp++;
    if (timed_out) begin
      n_bad++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs  = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({done, err, out_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: done/err/we=%b required 000", {done, err, out_we});
    end
    n_cmp++;
    if ({tok_addr, voc_addr, out_addr, out_wdata} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_addr: addrs/wdata=%h required 00000",
               {tok_addr, voc_addr, out_addr, out_wdata});
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || wr_cnt !== 0) begin
      n_bad++;
      $display("FAIL idle_hold: done=%b writes=%0d required 0 and 0", done, wr_cnt);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] exp [6] = '{8'h79, 8'h6F, 8'h20, 8'h68, 8'h69, 8'h00};
    int cyc, w0;
    bit to;
    prep(8'h02, 8'h01);
    w0 = wr_cnt;
    run_decode(cyc, to);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (out_mem[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL two_words_out[%0d]: got %h required %h", i, out_mem[i], exp[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL two_words_status: done=%b err=%b required 1 0", done, err);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 6) begin
      n_bad++;
      $display("FAIL two_words_writes: got %0d required 6", wr_cnt - w0);
    end
    n_cmp++;
    if (cyc !== 31) begin
      n_bad++;
      $display("FAIL two_words_latency: got %0d required 31", cyc);
    end
  endtask

  task automatic test_empty();
    int cyc, w0;
    bit to;
    prep(8'h00, 8'h00);
    w0 = wr_cnt;
    run_decode(cyc, to);
    n_cmp++;
    if (out_mem[0] !== 8'h00 || out_mem[1] !== 8'hEE) begin
      n_bad++;
      $display("FAIL empty_out: got %h %h required 00 ee", out_mem[0], out_mem[1]);
    end
    n_cmp++;
    if (wr_cnt - w0 !== 1 || err !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_status: writes=%0d err=%b done=%b required 1 0 1",
               wr_cnt - w0, err, done);
    end
    n_cmp++;
    if (cyc !== 4) begin
      n_bad++;
      $display("FAIL empty_latency: got %0d required 4", cyc);
    end
  endtask

  task automatic test_bad_token();
    int cyc, w0;
    bit to;
    prep(8'h05, 8'h00);
    w0 = wr_cnt;
    run_decode(cyc, to);
    n_cmp++;
    if (out_mem[0] !== 8'h00 || wr_cnt - w0 !== 1) begin
      n_bad++;
      $display("FAIL bad_token_out: got %h writes=%0d required 00 and 1",
               out_mem[0], wr_cnt - w0);
    end
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_token_status: err=%b done=%b required 1 1", err, done);
    end
  endtask

  task automatic test_truncate();
    logic [7:0] exp [16] = '{8'h68, 8'h69, 8'h20, 8'h68, 8'h69, 8'h20, 8'h68, 8'h69,
                             8'h20, 8'h68, 8'h69, 8'h20, 8'h68, 8'h69, 8'h20, 8'h00};
    int cyc;
    bit to;
    prep(8'h01, 8'h01);
    for (int i = 2; i < 8; i++) tok_mem[i] = 8'h01;
    run_decode(cyc, to);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (out_mem[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL trunc_out[%0d]: got %h required %h", i, out_mem[i], exp[i]);
      end
    end
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL trunc_status: err=%b done=%b required 1 1", err, done);
    end
  endtask

  task automatic test_reset_mid_copy();
    int cyc, w0;
    bit to;
    prep(8'h03, 8'h00);
    @(negedge clk) cs = 1'b1;
    @(negedge clk) cs = 1'b0;
    cyc = 0;
    while (!out_we && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (out_we !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_copy_reach: out_we=%b required 1", out_we);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_we !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_copy_rst: we=%b done=%b required 0 0", out_we, done);
    end
    @(negedge clk) rst = 1'b0;
    w0 = wr_cnt;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wr_cnt !== w0 || done !== 1'b0 || out_mem[0] !== 8'hEE) begin
      n_bad++;
      $display("FAIL mid_copy_quiet: writes=%0d done=%b out0=%h required 0 0 ee",
               wr_cnt - w0, done, out_mem[0]);
    end
    run_decode(cyc, to);
    n_cmp++;
    if ({out_mem[0], out_mem[1], out_mem[2]} !== 24'h6F6B00) begin
      n_bad++;
      $display("FAIL restart_out: got %h%h%h required 6f6b00",
               out_mem[0], out_mem[1], out_mem[2]);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_status: done=%b err=%b required 1 0", done, err);
    end
  endtask

  initial begin
    logic [7:0] voc_init [9] = '{8'h68, 8'h69, 8'h00, 8'h79, 8'h6F, 8'h00, 8'h6F, 8'h6B, 8'h00};
    for (int i = 0; i < 16; i++) voc_mem[i] = (i < 9) ? voc_init[i] : 8'h2E;
    prep(8'h00, 8'h00);
    test_reset();
    test_two_words();
    test_empty();
    test_bad_token();
    test_truncate();
    test_reset_mid_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
